s_p_frame_ctrl: RTL and testbench
=================================

Name: s_p_frame_ctrl

Overview:
- Frame sequencer for the serial-to-parallel converter datapath: shift chain of C_BITS_OUT flops plus an output latch bank.
- Detects a start-of-frame strobe and gates the shift chain for exactly C_BITS_OUT bits.
- Issues a one-cycle latch enable to the output bank and presents the latched word to a consumer through a VALID/READY handshake.
- Detects overrun (new word done before the previous one is consumed), drops the new word, and reports it via sticky flag and saturating drop counter.

Parameters:
- C_BITS_OUT, 255, bits per frame (>=2).
- C_DROP_W, 8, width of the dropped-frame counter.

Ports:
- CK  in  1  clock, all state on rising edge.
- RST  in  1  asynchronous reset, active-low (RST=0 resets).
- SOF  in  1  start-of-frame strobe, coincident with frame bit 0 on D.
- READY  in  1  consumer accepts the held word when VALID&READY.
- CLR_OVF  in  1  synchronous clear of OVF and DROP_CNT.
- SHIFT_EN  out  1  shift-chain clock enable (combinational).
- LATCH_EN  out  1  output-latch enable, one cycle (combinational).
- BIT_CNT  out  $clog2(C_BITS_OUT+1)  bits shifted in the current frame.
- BUSY  out  1  frame in progress (state != IDLE).
- VALID  out  1  latched word available.
- OVF  out  1  sticky overrun flag.
- DROP_CNT  out  C_DROP_W  dropped frames, saturating.

Behaviour:
- Reset (RST=0, async): state=IDLE, BIT_CNT=0, VALID=0, OVF=0, DROP_CNT=0. SHIFT_EN and LATCH_EN are 0 while in reset.
- States: IDLE, SHIFT, LATCH.
- IDLE:
  - SOF=1: SHIFT_EN=1, BIT_CNT<=1, go to SHIFT.
  - Otherwise stay; SHIFT_EN=0.
- SHIFT:
  - SHIFT_EN=1 every cycle; BIT_CNT increments.
  - On the cycle BIT_CNT==C_BITS_OUT-1, that bit is the last: next state LATCH, BIT_CNT<=C_BITS_OUT.
  - SOF is ignored in SHIFT (no restart).
- LATCH (exactly one cycle):
  - LATCH_EN = !(VALID & !READY).
  - If SOF=1, SHIFT_EN=1, BIT_CNT<=1, go to SHIFT (back-to-back frames, zero gap). Otherwise BIT_CNT<=0, go to IDLE.
- Latency: frame starting at cycle t (SOF=1) has its last bit at t+C_BITS_OUT-1, LATCH at t+C_BITS_OUT, VALID high from t+C_BITS_OUT+1.
- VALID update (priority order):
  1. LATCH_EN=1 sets VALID=1.
  2. Otherwise VALID&READY clears VALID.
  3. Otherwise VALID holds.
- Accept-and-replace: LATCH with VALID=1 and READY=1 is a handshake plus a new latch in the same cycle; VALID stays 1.
- Overrun: LATCH with VALID=1 and READY=0:
  - LATCH_EN=0; held word is preserved.
  - OVF<=1.
  - DROP_CNT increments, saturating at all-ones.
- CLR_OVF=1 clears OVF and DROP_CNT next edge. If an overrun occurs in the same cycle, the overrun wins: OVF=1, DROP_CNT=1.
- READY while VALID=0 has no effect.
- Reset mid-frame aborts the frame; partial data is never latched; VALID drops immediately.
- BUSY = (state != IDLE).

Test Plan (C_BITS_OUT=8):
- Single frame: SOF pulse at cycle 10, READY=1. Required:
  - SHIFT_EN high for cycles 10-17.
  - LATCH_EN pulses at cycle 18.
  - VALID high at cycle 19, cleared at cycle 20.
  - BIT_CNT sequence 1..8, then 0.
- Back-to-back frames: SOF at cycles 10 and 18. Required:
  - SHIFT_EN continuous for cycles 10-25.
  - LATCH_EN pulses at cycles 18 and 26.
  - BUSY never drops between frames.
- Overrun: READY=0 throughout, three frames. Required:
  - First LATCH_EN=1; second and third LATCH_EN=0.
  - OVF=1 after the second frame.
  - DROP_CNT=2.
  - VALID stays 1.
- Accept-and-replace: READY=1 only on the second LATCH cycle. Required: LATCH_EN=1, VALID stays 1, OVF=0.
- Clear and saturation (C_DROP_W=2): force 5 overruns. Required:
  - DROP_CNT saturates at 3.
  - CLR_OVF pulse gives OVF=0, DROP_CNT=0.
  - CLR_OVF coincident with an overrun gives OVF=1, DROP_CNT=1.
- Async reset: assert RST=0 at BIT_CNT=4, mid-cycle. Required:
  - All outputs 0 immediately, without a clock edge.
  - SOF-less cycles after release give no SHIFT_EN.
  - SOF ignored in SHIFT: pulse SOF at BIT_CNT=3; required no restart, LATCH still at the 8th bit.

Source files
------------

// File: rtl/s_p_frame_ctrl.sv
// Frame sequencer for the serial-to-parallel datapath: gates the shift chain for one
// frame, pulses the output-latch enable and holds the word behind a VALID/READY handshake.
module s_p_frame_ctrl #(
    parameter int C_BITS_OUT = 255,
    parameter int C_DROP_W   = 8
) (
    input  logic                            CK,
    input  logic                            RST,
    input  logic                            SOF,
    input  logic                            READY,
    input  logic                            CLR_OVF,
    output logic                            SHIFT_EN,
    output logic                            LATCH_EN,
    output logic [$clog2(C_BITS_OUT+1)-1:0] BIT_CNT,
    output logic                            BUSY,
    output logic                            VALID,
    output logic                            OVF,
    output logic [C_DROP_W-1:0]             DROP_CNT
);
    localparam int CW = $clog2(C_BITS_OUT + 1);
    localparam logic [CW-1:0] LAST = CW'(C_BITS_OUT - 1);
    localparam logic [CW-1:0] FULL = CW'(C_BITS_OUT);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  valid_q, valid_d;
    logic                  ovf_q, ovf_d;
    logic [C_DROP_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic                  shift_en, latch_en, overrun;

    always_ff @(posedge CK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_en  = 1'b0;
        latch_en  = 1'b0;
        overrun   = 1'b0;
        case (state_q)
            IDLE: begin
                if (SOF) begin
                    shift_en  = 1'b1;
                    bit_cnt_d = CW'(1);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // SOF is deliberately ignored here: a frame always runs to completion
                shift_en = 1'b1;
                if (bit_cnt_q == LAST) begin
                    bit_cnt_d = FULL;
                    state_d   = LATCH;
                end else begin
                    bit_cnt_d = bit_cnt_q + CW'(1);
                end
            end
            LATCH: begin
                overrun  = valid_q & ~READY;
                latch_en = ~overrun;
                if (SOF) begin
                    shift_en  = 1'b1;
                    bit_cnt_d = CW'(1);
                    state_d   = SHIFT;
                end else begin
                    bit_cnt_d = '0;
                    state_d   = IDLE;
                end
            end
            default: begin
                bit_cnt_d = '0;
                state_d   = IDLE;
            end
        endcase

        valid_d = valid_q;
        if (latch_en)
            valid_d = 1'b1;
        else if (valid_q && READY)
            valid_d = 1'b0;

        ovf_d      = ovf_q;
        drop_cnt_d = drop_cnt_q;
        if (CLR_OVF) begin
            ovf_d      = 1'b0;
            drop_cnt_d = '0;
        end
        // An overrun in the clear cycle still counts, on top of the cleared value
        if (overrun) begin
            ovf_d = 1'b1;
            if (!(&drop_cnt_d))
                drop_cnt_d = drop_cnt_d + C_DROP_W'(1);
        end
    end

    assign SHIFT_EN = shift_en & RST;
    assign LATCH_EN = latch_en & RST;
    assign BIT_CNT  = bit_cnt_q;
    assign BUSY     = (state_q != IDLE);
    assign VALID    = valid_q;
    assign OVF      = ovf_q;
    assign DROP_CNT = drop_cnt_q;
endmodule

// File: tb/tb_s_p_frame_ctrl.sv
// Directed bench for s_p_frame_ctrl with 8-bit frames and a 2-bit drop counter.
module tb_s_p_frame_ctrl;
    localparam int NB = 8;
    localparam int DW = 2;

    logic CK = 1'b0;
    logic RST, SOF, READY, CLR_OVF;
    logic SHIFT_EN, LATCH_EN, BUSY, VALID, OVF;
    logic [$clog2(NB+1)-1:0] BIT_CNT;
    logic [DW-1:0] DROP_CNT;

    int n_tests = 0;
    int n_fail  = 0;

    s_p_frame_ctrl #(.C_BITS_OUT(NB), .C_DROP_W(DW)) dut (
        .CK(CK), .RST(RST), .SOF(SOF), .READY(READY), .CLR_OVF(CLR_OVF),
        .SHIFT_EN(SHIFT_EN), .LATCH_EN(LATCH_EN), .BIT_CNT(BIT_CNT),
        .BUSY(BUSY), .VALID(VALID), .OVF(OVF), .DROP_CNT(DROP_CNT)
    );

    always #5 CK = ~CK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge and let combinational outputs settle.
    task automatic step(input logic s, input logic r, input logic c);
        @(negedge CK);
        SOF = s; READY = r; CLR_OVF = c;
        #1;
    endtask

    // One frame: optional SOF cycle, NB-1 shift cycles, then the LATCH cycle.
    task automatic frame(input logic started, input logic rdy, input logic rdy_l,
                         input logic clr_l, input logic sof_l, input logic exp_le);
        if (!started) begin
            step(1'b1, rdy, 1'b0);
            chk("sof_shift_en", SHIFT_EN, 1);
            chk("sof_bit_cnt", BIT_CNT, 0);
        end
        for (int k = 1; k < NB; k++) begin
            step(1'b0, rdy, 1'b0);
            chk("shift_en", SHIFT_EN, 1);
            chk("shift_bit_cnt", BIT_CNT, k);
            chk("shift_busy", BUSY, 1);
            chk("shift_latch_en", LATCH_EN, 0);
        end
        step(sof_l, rdy_l, clr_l);
        chk("latch_latch_en", LATCH_EN, exp_le);
        chk("latch_bit_cnt", BIT_CNT, NB);
        chk("latch_shift_en", SHIFT_EN, sof_l);
        chk("latch_busy", BUSY, 1);
    endtask

    initial begin
        RST = 1'b0; SOF = 1'b0; READY = 1'b0; CLR_OVF = 1'b0;
        #1;
        chk("rst_shift_en", SHIFT_EN, 0);
        chk("rst_latch_en", LATCH_EN, 0);
        chk("rst_bit_cnt", BIT_CNT, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_valid", VALID, 0);
        chk("rst_ovf", OVF, 0);
        chk("rst_drop", DROP_CNT, 0);
        @(negedge CK);
        RST = 1'b1;

        // single frame, READY high throughout
        step(1'b0, 1'b1, 1'b0);
        chk("idle_shift_en", SHIFT_EN, 0);
        chk("idle_busy", BUSY, 0);
        frame(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        chk("s1_valid", VALID, 1);
        chk("s1_bit_cnt", BIT_CNT, 0);
        chk("s1_busy", BUSY, 0);
        chk("s1_latch_en", LATCH_EN, 0);
        step(1'b0, 1'b1, 1'b0);
        chk("s1_valid_clr", VALID, 0);

        // back-to-back frames, zero gap
        frame(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        frame(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        chk("b2b_valid", VALID, 1);
        chk("b2b_busy", BUSY, 0);
        step(1'b0, 1'b1, 1'b0);
        chk("b2b_valid_clr", VALID, 0);

        // overrun with READY low: first latches, next two are dropped
        frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("ovr1_valid", VALID, 1);
        chk("ovr1_ovf", OVF, 0);
        frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("ovr2_ovf", OVF, 1);
        chk("ovr2_drop", DROP_CNT, 1);
        chk("ovr2_valid", VALID, 1);
        frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("ovr3_drop", DROP_CNT, 2);
        chk("ovr3_valid", VALID, 1);

        // clear, then accept-and-replace with READY only on the LATCH cycle
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("clr_ovf", OVF, 0);
        chk("clr_drop", DROP_CNT, 0);
        chk("clr_valid_kept", VALID, 1);
        frame(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("ar_valid", VALID, 1);
        chk("ar_ovf", OVF, 0);
        chk("ar_drop", DROP_CNT, 0);

        // five overruns saturate the 2-bit counter at 3
        for (int i = 1; i <= 5; i++) begin
            frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
            chk("sat_drop", DROP_CNT, (i > 3) ? 3 : i);
            chk("sat_ovf", OVF, 1);
        end
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("sat_clr_ovf", OVF, 0);
        chk("sat_clr_drop", DROP_CNT, 0);
        frame(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("clr_ovr_ovf", OVF, 1);
        chk("clr_ovr_drop", DROP_CNT, 1);

        // SOF mid-frame must not restart the count
        step(1'b1, 1'b0, 1'b0);
        for (int k = 1; k < NB; k++) begin
            step((k == 3) ? 1'b1 : 1'b0, 1'b0, 1'b0);
            chk("sofig_bit_cnt", BIT_CNT, k);
            chk("sofig_shift_en", SHIFT_EN, 1);
        end
        step(1'b0, 1'b1, 1'b0);
        chk("sofig_latch_en", LATCH_EN, 1);
        chk("sofig_latch_cnt", BIT_CNT, NB);

        // async reset mid-frame, between clock edges
        step(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) step(1'b0, 1'b0, 1'b0);
        chk("pre_rst_bit_cnt", BIT_CNT, 4);
        chk("pre_rst_valid", VALID, 1);
        #2;
        RST = 1'b0;
        #1;
        chk("arst_shift_en", SHIFT_EN, 0);
        chk("arst_latch_en", LATCH_EN, 0);
        chk("arst_bit_cnt", BIT_CNT, 0);
        chk("arst_busy", BUSY, 0);
        chk("arst_valid", VALID, 0);
        chk("arst_ovf", OVF, 0);
        chk("arst_drop", DROP_CNT, 0);
        @(negedge CK);
        RST = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'b0);
            chk("post_rst_shift_en", SHIFT_EN, 0);
            chk("post_rst_busy", BUSY, 0);
            chk("post_rst_bit_cnt", BIT_CNT, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
